// File: rtl/hydra_pkg.sv
// Shared types for the hydra switch ingress path: control-word layout,
// packer FSM states and switch port count.
package hydra_pkg;

  localparam int PORT_NUM = 16;

  // Control word prefixed to every packet handed to a hydra write port.
  typedef struct packed {
    logic [8:0] len;   // payload words - 1
    logic [2:0] prio;
    logic [3:0] dest;
  } ctrl_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DROP,
    ST_ARM,
    ST_SOP,
    ST_CTRL,
    ST_DATA,
    ST_EOP
  } pk_state_t;

endpackage

// File: rtl/hydra_ingress_packer_if.sv
// Ingress word stream, switch pause bit, hydra write-port signals and the
// drop counter of one packer. slave = the packer, master = its environment.
interface hydra_ingress_packer_if;
  logic        in_vld;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic [3:0]  in_dest;
  logic [2:0]  in_prio;
  logic        pause;
  logic        wr_sop;
  logic        wr_vld;
  logic [15:0] wr_data;
  logic        wr_eop;
  logic [15:0] drop_cnt;

  modport master (
    output in_vld, in_data, in_last, in_dest, in_prio, pause,
    input  in_ready, wr_sop, wr_vld, wr_data, wr_eop, drop_cnt
  );

  modport slave (
    input  in_vld, in_data, in_last, in_dest, in_prio, pause,
    output in_ready, wr_sop, wr_vld, wr_data, wr_eop, drop_cnt
  );
endinterface

// File: rtl/hydra_ingress_packer_buf.sv
// packer_buf: simple dual-port DEPTH x 16 payload RAM, synchronous write,
// registered read (one cycle read latency).
module packer_buf #(
  parameter int DEPTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [15:0]              i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [15:0]              o_rdata
);
  logic [15:0] r_mem [DEPTH];
  logic [15:0] r_rdata;

  // Write port and registered read port.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/hydra_ingress_packer.sv
// hydra_ingress_packer: buffers one whole ingress packet, then replays it to
// a hydra write port as SOP, control word, payload, EOP. A packet is started
// only while pause is low. Oversize packets (more than DEPTH words) are
// dropped. Optional feature macro: HYDRA_PACKER_DROP_CNT_EN enables the
// saturating 16-bit drop counter; otherwise drop_cnt is tied to zero.
module hydra_ingress_packer
  import hydra_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input logic                   clk,
  input logic                   rst,
  hydra_ingress_packer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  pk_state_t     r_state, w_next;
  logic [9:0]    r_count;
  logic [9:0]    r_oidx;
  logic [AW-1:0] r_rptr;
  logic [3:0]    r_dest;
  logic [2:0]    r_prio;
  logic          r_wr_sop, r_wr_vld, r_wr_eop;
  logic [15:0]   r_wr_data;

  logic          w_accept, w_ready, w_we;
  logic [AW-1:0] w_waddr;
  logic [15:0]   w_rd_data;
  logic [8:0]    w_len;
  ctrl_word_t    w_ctrl;
  logic          w_sop_nx, w_vld_nx, w_eop_nx;
  logic [15:0]   w_data_nx;

  assign w_ready      = ((r_state == ST_IDLE) || (r_state == ST_COLLECT) ||
                         (r_state == ST_DROP)) && !rst;
  assign w_accept     = bus.in_vld && w_ready;
  assign bus.in_ready = w_ready;
  assign w_len        = 9'(r_count - 10'd1);

  // Control word assembled from the latched header fields and word count.
  always_comb begin
    w_ctrl.len  = w_len;
    w_ctrl.prio = r_prio;
    w_ctrl.dest = r_dest;
  end

  packer_buf #(.DEPTH(DEPTH)) u_buf (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (bus.in_data),
    .i_raddr (r_rptr),
    .o_rdata (w_rd_data)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state, buffer write strobe and next values of the registered outputs.
  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = r_count[AW-1:0];
    unique case (r_state)
      ST_IDLE: if (w_accept) begin
        w_we    = 1'b1;
        w_waddr = '0;
        w_next  = bus.in_last ? ST_ARM : ST_COLLECT;
      end
      ST_COLLECT: if (w_accept) begin
        // A word arriving with the buffer already full makes the packet
        // oversize; if it is also the last word the drop completes at once.
        if (r_count == 10'(DEPTH)) begin
          w_next = bus.in_last ? ST_IDLE : ST_DROP;
        end else begin
          w_we = 1'b1;
          if (bus.in_last) w_next = ST_ARM;
        end
      end
      ST_DROP: if (w_accept && bus.in_last) w_next = ST_IDLE;
      ST_ARM:  if (!bus.pause) w_next = ST_SOP;
      ST_SOP:  w_next = ST_CTRL;
      ST_CTRL: w_next = ST_DATA;
      ST_DATA: if (r_oidx == r_count) w_next = ST_EOP;
      ST_EOP:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase

    w_sop_nx  = (w_next == ST_SOP);
    w_vld_nx  = (w_next == ST_CTRL) || (w_next == ST_DATA);
    w_eop_nx  = (w_next == ST_EOP);
    w_data_nx = '0;
    if (w_next == ST_CTRL)      w_data_nx = w_ctrl;
    else if (w_next == ST_DATA) w_data_nx = w_rd_data;
  end

  // Word count, header latch, read pointer and emitted-word index.
  // The read pointer is 0 during SOP so RAM data lines up one cycle ahead
  // of the registered wr_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_dest  <= '0;
      r_prio  <= '0;
      r_rptr  <= '0;
      r_oidx  <= '0;
    end else begin
      if (r_state == ST_IDLE && w_accept) begin
        r_count <= 10'd1;
        r_dest  <= bus.in_dest;
        r_prio  <= bus.in_prio;
      end else if (r_state == ST_COLLECT && w_we) begin
        r_count <= r_count + 10'd1;
      end

      if (r_state == ST_SOP || r_state == ST_CTRL || r_state == ST_DATA)
        r_rptr <= r_rptr + AW'(1);
      else
        r_rptr <= '0;

      if (r_state == ST_CTRL)      r_oidx <= 10'd1;
      else if (r_state == ST_DATA) r_oidx <= r_oidx + 10'd1;
    end
  end

  // Registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_sop  <= 1'b0;
      r_wr_vld  <= 1'b0;
      r_wr_eop  <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_wr_sop  <= w_sop_nx;
      r_wr_vld  <= w_vld_nx;
      r_wr_eop  <= w_eop_nx;
      r_wr_data <= w_data_nx;
    end
  end

  assign bus.wr_sop  = r_wr_sop;
  assign bus.wr_vld  = r_wr_vld;
  assign bus.wr_eop  = r_wr_eop;
  assign bus.wr_data = r_wr_data;

`ifdef HYDRA_PACKER_DROP_CNT_EN
  logic        w_drop_inc;
  logic [15:0] r_drop_cnt;

  assign w_drop_inc = w_accept && bus.in_last &&
                      ((r_state == ST_DROP) ||
                       (r_state == ST_COLLECT && r_count == 10'(DEPTH)));

  // Saturating count of dropped oversize packets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_drop_cnt <= '0;
    else if (w_drop_inc && r_drop_cnt != '1)  r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign bus.drop_cnt = r_drop_cnt;
`else
  assign bus.drop_cnt = '0;
`endif
endmodule

// File: tb/tb_hydra_ingress_packer.sv
// Directed bench for hydra_ingress_packer (DEPTH = 64).
module tb_hydra_ingress_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef HYDRA_PACKER_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP = 16'd1;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  hydra_ingress_packer_if bus();

  hydra_ingress_packer #(.DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] vld_q[$];
  int          vcyc_q[$];
  int          sop_q[$];
  int          eop_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_sop === 1'b1) sop_q.push_back(cyc);
      if (bus.wr_eop === 1'b1) eop_q.push_back(cyc);
      if (bus.wr_vld === 1'b1) begin
        vld_q.push_back(bus.wr_data);
        vcyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    vld_q.delete(); vcyc_q.delete(); sop_q.delete(); eop_q.delete();
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [15:0] d, input logic last,
                           input logic [3:0] dest, input logic [2:0] prio,
                           output int t);
    bit got = 0;
    t = -1;
    bus.in_vld = 1'b1; bus.in_data = d; bus.in_last = last;
    bus.in_dest = dest; bus.in_prio = prio;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin got = 1; t = cyc; end
      @(posedge clk); #1;
    end
    bus.in_vld = 1'b0; bus.in_last = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  // Header fields are driven only on the first word; later words carry
  // inverted values that the packer must ignore.
  task automatic send_pkt(input int n, input logic [15:0] base,
                          input logic [3:0] dest, input logic [2:0] prio,
                          output int t_last);
    for (int i = 0; i < n; i++)
      send_word(16'(base + i), (i == n - 1), (i == 0) ? dest : ~dest,
                (i == 0) ? prio : ~prio, t_last);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.in_ready, bus.wr_sop, bus.wr_vld, bus.wr_eop, bus.wr_data, bus.drop_cnt} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b sop=%b vld=%b eop=%b data=%h drop=%h, required all 0",
               bus.in_ready, bus.wr_sop, bus.wr_vld, bus.wr_eop, bus.wr_data, bus.drop_cnt);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_idle_ready: got %b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic32();
    int t;
    clear_q();
    send_pkt(32, 16'h0000, 4'd5, 3'd2, t);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL basic_ready_fall: got %b, required 0", bus.in_ready);
    end
    @(posedge clk); #1;
    wait_to(t + 45);
    n_cmp++;
    if (sop_q.size() != 1 || sop_q[0] != t + 2) begin
      n_bad++; $display("FAIL basic_sop: count %0d first %0d, required 1 at %0d",
                        sop_q.size(), (sop_q.size() > 0) ? sop_q[0] : -1, t + 2);
    end
    n_cmp++;
    if (vld_q.size() != 33) begin
      n_bad++; $display("FAIL basic_vld_count: got %0d, required 33", vld_q.size());
    end
    n_cmp++;
    if (vld_q.size() < 1 || vld_q[0] !== 16'h0FA5 || vcyc_q[0] != t + 3) begin
      n_bad++; $display("FAIL basic_ctrl: got %h at %0d, required 0fa5 at %0d",
                        (vld_q.size() > 0) ? vld_q[0] : 16'hxxxx,
                        (vcyc_q.size() > 0) ? vcyc_q[0] : -1, t + 3);
    end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (i + 1 >= vld_q.size() || vld_q[i + 1] !== 16'(i)) begin
        n_bad++; $display("FAIL basic_payload[%0d]: got %h, required %h", i,
                          (i + 1 < vld_q.size()) ? vld_q[i + 1] : 16'hxxxx, 16'(i));
      end
    end
    n_cmp++;
    if (eop_q.size() != 1 || eop_q[0] != t + 36) begin
      n_bad++; $display("FAIL basic_eop: count %0d first %0d, required 1 at %0d",
                        eop_q.size(), (eop_q.size() > 0) ? eop_q[0] : -1, t + 36);
    end
  endtask

  task automatic test_one_word();
    int t;
    clear_q();
    send_pkt(1, 16'hBEEF, 4'hA, 3'd7, t);
    wait_to(t + 10);
    n_cmp++;
    if (vld_q.size() != 2 || vld_q[0] !== 16'h007A || vld_q[1] !== 16'hBEEF) begin
      n_bad++; $display("FAIL one_word_data: count %0d, required 2 words 007a beef", vld_q.size());
    end
    n_cmp++;
    if (eop_q.size() != 1 || vcyc_q.size() < 1 || eop_q[0] != vcyc_q[0] + 2) begin
      n_bad++; $display("FAIL one_word_eop: eop %0d, required ctrl cycle + 2 = %0d",
                        (eop_q.size() > 0) ? eop_q[0] : -1,
                        (vcyc_q.size() > 0) ? vcyc_q[0] + 2 : -1);
    end
  endtask

  task automatic test_back_to_back();
    int ta, tb;
    clear_q();
    send_pkt(1, 16'h1111, 4'd2, 3'd1, ta);
    send_pkt(1, 16'h2222, 4'd3, 3'd1, tb);
    wait_to(tb + 10);
    n_cmp++;
    if (sop_q.size() != 2 || eop_q.size() != 2 || sop_q[1] - eop_q[0] != 3) begin
      n_bad++; $display("FAIL b2b_gap: sops %0d eops %0d gap %0d, required 2 2 3",
                        sop_q.size(), eop_q.size(),
                        (sop_q.size() > 1 && eop_q.size() > 0) ? sop_q[1] - eop_q[0] : -1);
    end
    n_cmp++;
    if (vld_q.size() != 4 || vld_q[3] !== 16'h2222 || vld_q[2] !== 16'h0013) begin
      n_bad++; $display("FAIL b2b_data: count %0d, required 4 ending 0013 2222", vld_q.size());
    end
  endtask

  task automatic test_pause();
    int t;
    clear_q();
    bus.pause = 1'b1;
    send_pkt(8, 16'h3000, 4'd3, 3'd1, t);
    wait_to(t + 11);
    n_cmp++;
    if (sop_q.size() != 0 || bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL pause_hold: sops %0d ready %b, required 0 0", sop_q.size(), bus.in_ready);
    end
    bus.pause = 1'b0;
    wait_to(t + 16);
    bus.pause = 1'b1;
    wait_to(t + 30);
    bus.pause = 1'b0;
    n_cmp++;
    if (sop_q.size() != 1 || sop_q[0] != t + 12) begin
      n_bad++; $display("FAIL pause_sop: first %0d, required %0d",
                        (sop_q.size() > 0) ? sop_q[0] : -1, t + 12);
    end
    n_cmp++;
    if (vld_q.size() != 9 || vld_q[0] !== 16'h0393) begin
      n_bad++; $display("FAIL pause_ctrl: count %0d ctrl %h, required 9 0393", vld_q.size(),
                        (vld_q.size() > 0) ? vld_q[0] : 16'hxxxx);
    end
    for (int i = 1; i < 9; i++) begin
      n_cmp++;
      if (i >= vcyc_q.size() || vcyc_q[i] != vcyc_q[0] + i || vld_q[i] !== 16'(16'h3000 + i - 1)) begin
        n_bad++; $display("FAIL pause_contig[%0d]: got %h at %0d, required %h at %0d", i,
                          (i < vld_q.size()) ? vld_q[i] : 16'hxxxx,
                          (i < vcyc_q.size()) ? vcyc_q[i] : -1, 16'(16'h3000 + i - 1), t + 13 + i);
      end
    end
    n_cmp++;
    if (eop_q.size() != 1 || eop_q[0] != t + 22) begin
      n_bad++; $display("FAIL pause_eop: got %0d, required %0d",
                        (eop_q.size() > 0) ? eop_q[0] : -1, t + 22);
    end
  endtask

  task automatic test_exact_depth();
    int t;
    clear_q();
    send_pkt(64, 16'h4000, 4'hF, 3'd0, t);
    wait_to(t + 75);
    n_cmp++;
    if (vld_q.size() != 65 || vld_q[0] !== 16'h1F8F) begin
      n_bad++; $display("FAIL depth_ctrl: count %0d ctrl %h, required 65 1f8f", vld_q.size(),
                        (vld_q.size() > 0) ? vld_q[0] : 16'hxxxx);
    end
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (i + 1 >= vld_q.size() || vld_q[i + 1] !== 16'(16'h4000 + i)) begin
        n_bad++; $display("FAIL depth_payload[%0d]: got %h, required %h", i,
                          (i + 1 < vld_q.size()) ? vld_q[i + 1] : 16'hxxxx, 16'(16'h4000 + i));
      end
    end
    n_cmp++;
    if (eop_q.size() != 1 || eop_q[0] != t + 68) begin
      n_bad++; $display("FAIL depth_eop: got %0d, required %0d",
                        (eop_q.size() > 0) ? eop_q[0] : -1, t + 68);
    end
  endtask

  task automatic test_oversize();
    int t;
    clear_q();
    send_pkt(69, 16'h5000, 4'd6, 3'd6, t);
    wait_to(t + 20);
    n_cmp++;
    if (sop_q.size() != 0 || vld_q.size() != 0) begin
      n_bad++; $display("FAIL oversize_emit: sops %0d words %0d, required 0 0", sop_q.size(), vld_q.size());
    end
    @(negedge clk);
    n_cmp++;
    if (bus.drop_cnt !== EXP_DROP) begin
      n_bad++; $display("FAIL oversize_drop_cnt: got %0d, required %0d", bus.drop_cnt, EXP_DROP);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL oversize_idle: ready %b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    send_pkt(4, 16'h6000, 4'd9, 3'd4, t);
    wait_to(t + 12);
    n_cmp++;
    if (vld_q.size() != 5 || vld_q[0] !== 16'h01C9 || vld_q[1] !== 16'h6000 || vld_q[4] !== 16'h6003) begin
      n_bad++; $display("FAIL oversize_next: count %0d ctrl %h, required 5 01c9 6000..6003", vld_q.size(),
                        (vld_q.size() > 0) ? vld_q[0] : 16'hxxxx);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    clear_q();
    for (int i = 0; i < 10; i++)
      send_word(16'(16'h7000 + i), 1'b0, (i == 0) ? 4'd8 : 4'd0, 3'd5, t);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.in_ready, bus.wr_sop, bus.wr_vld, bus.wr_eop, bus.wr_data, bus.drop_cnt} !== 36'd0) begin
      n_bad++; $display("FAIL midrst_outputs: rdy=%b sop=%b vld=%b eop=%b data=%h drop=%h, required all 0",
                        bus.in_ready, bus.wr_sop, bus.wr_vld, bus.wr_eop, bus.wr_data, bus.drop_cnt);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    send_pkt(6, 16'h8000, 4'd1, 3'd3, t);
    wait_to(t + 15);
    n_cmp++;
    if (vld_q.size() != 7 || vld_q[0] !== 16'h02B1) begin
      n_bad++; $display("FAIL midrst_ctrl: count %0d ctrl %h, required 7 02b1", vld_q.size(),
                        (vld_q.size() > 0) ? vld_q[0] : 16'hxxxx);
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (i + 1 >= vld_q.size() || vld_q[i + 1] !== 16'(16'h8000 + i)) begin
        n_bad++; $display("FAIL midrst_payload[%0d]: got %h, required %h", i,
                          (i + 1 < vld_q.size()) ? vld_q[i + 1] : 16'hxxxx, 16'(16'h8000 + i));
      end
    end
  endtask

  initial begin
    bus.in_vld = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.in_dest = '0; bus.in_prio = '0; bus.pause = 1'b0;
    test_reset();
    test_basic32();
    test_one_word();
    test_back_to_back();
    test_pause();
    test_exact_depth();
    test_oversize();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
